// File: rtl/sad_min_select.sv
`default_nettype none
// sad_min_select: streaming minimum-SAD selector over a raster search window, rev 1.0.
// Optional early termination on SAD <= threshold when SAD_EARLY_TERM_EN is defined.
module sad_min_select #(
  parameter int SAD_W    = 12,
  parameter int SEARCH_W = 4,
  parameter int SEARCH_H = 4,
  parameter int COORD_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SAD_W-1:0]     in_sad,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SAD_W-1:0]     out_sad,
  output logic [2*COORD_W-1:0] out_mv,
`ifdef SAD_EARLY_TERM_EN
  input  logic [SAD_W-1:0]     thresh,
  output logic                 out_early,
`endif
  output logic                 busy
);

  localparam int TOTAL = SEARCH_W * SEARCH_H;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic [SAD_W-1:0]     min_q, min_d;
  logic [2*COORD_W-1:0] mv_q, mv_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 accept, last, hit;

`ifdef SAD_EARLY_TERM_EN
  logic [SAD_W-1:0] thresh_q, thresh_d;
  logic             early_q, early_d;
  assign hit = (in_sad <= thresh_q);
`else
  assign hit = 1'b0;
`endif

  assign accept = in_valid && in_ready_q;
  assign last   = (cnt_q == CNT_W'(TOTAL - 1));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    min_d       = min_q;
    mv_d        = mv_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef SAD_EARLY_TERM_EN
    thresh_d    = thresh_q;
    early_d     = early_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          x_d        = '0;
          y_d        = '0;
          cnt_d      = '0;
          first_d    = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
`ifdef SAD_EARLY_TERM_EN
          thresh_d   = thresh;
          early_d    = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (accept) begin
          first_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          // Strict less-than keeps the earliest raster index on ties.
          if (first_q || (in_sad < min_q)) begin
            min_d = in_sad;
            mv_d  = {y_q, x_q};
          end
          if (x_q == COORD_W'(SEARCH_W - 1)) begin
            x_d = '0;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
          if (last || hit) begin
            state_d     = DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
`ifdef SAD_EARLY_TERM_EN
            early_d     = hit;
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
`ifdef SAD_EARLY_TERM_EN
          early_d     = 1'b0;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      min_q       <= '0;
      mv_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SAD_EARLY_TERM_EN
      thresh_q    <= '0;
      early_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      min_q       <= min_d;
      mv_q        <= mv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SAD_EARLY_TERM_EN
      thresh_q    <= thresh_d;
      early_q     <= early_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sad   = min_q;
  assign out_mv    = mv_q;
`ifdef SAD_EARLY_TERM_EN
  assign out_early = early_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_min_select.sv
`default_nettype none
// tb_sad_min_select: directed vectors with hand-computed results for sad_min_select.
module tb_sad_min_select;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_sad = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sad;
  logic [7:0]  out_mv;
  logic        busy;
`ifdef SAD_EARLY_TERM_EN
  logic [11:0] thresh = '0;
  logic        out_early;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [11:0] vec [16];

  sad_min_select dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sad   (in_sad),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sad  (out_sad),
    .out_mv   (out_mv),
`ifdef SAD_EARLY_TERM_EN
    .thresh   (thresh),
    .out_early(out_early),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic begin_search();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Present vec[0..n-1]; each candidate is held until accepted.
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        in_valid = 1'b0;
        repeat (g) step();
      end
      in_valid = 1'b1;
      in_sad   = vec[i];
      t = 0;
      while (!in_ready && t < 20) begin
        step();
        t++;
      end
      if (t >= 20) chk("accept_timeout", 32'd0, 32'd1);
      if (i == n - 1) chk("pre_final_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [11:0] sad, input logic [7:0] mv);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_sad"}, 32'(out_sad), 32'(sad));
    chk({tag, "_out_mv"}, 32'(out_mv), 32'(mv));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sad", 32'(out_sad), 32'd0);
    chk("rst_out_mv", 32'(out_mv), 32'd0);
    rst_n = 1'b1;
    step();

    // Descending 100..85: last candidate is the minimum at (3,3).
    for (int i = 0; i < 16; i++) vec[i] = 12'(100 - i);
    begin_search();
    feed(16, 1'b0);
    expect_result("desc", 12'd85, 8'h33);
    release_result("desc");

    // Equal values: the first candidate wins.
    for (int i = 0; i < 16; i++) vec[i] = 12'd50;
    begin_search();
    feed(16, 1'b0);
    expect_result("tie", 12'd50, 8'h00);
    release_result("tie");

    // Two equal minima at idx6 and idx9 with input gaps; then stall the output.
    for (int i = 0; i < 16; i++) vec[i] = 12'd200;
    vec[6] = 12'd3;
    vec[9] = 12'd3;
    begin_search();
    feed(16, 1'b1);
    expect_result("gap", 12'd3, 8'h12);
    for (int c = 0; c < 5; c++) begin
      start    = (c % 2 == 0);
      in_valid = 1'b1;
      in_sad   = 12'd1;
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_sad", 32'(out_sad), 32'd3);
      chk("hold_out_mv", 32'(out_mv), 32'h12);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    release_result("hold");
    chk("hold_idle_in_ready", 32'(in_ready), 32'd0);

    // Abort after 7 accepts via reset.
    for (int i = 0; i < 16; i++) vec[i] = 12'(30 + i);
    begin_search();
    feed(7, 1'b0);
    rst_n = 1'b0;
    step();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_sad", 32'(out_sad), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_stay_idle", 32'(out_valid | busy), 32'd0);
    end

    // All-max window returns index 0.
    for (int i = 0; i < 16; i++) vec[i] = 12'hFFF;
    begin_search();
    feed(16, 1'b0);
    expect_result("max", 12'd4095, 8'h00);
    release_result("max");

`ifdef SAD_EARLY_TERM_EN
    for (int i = 0; i < 16; i++) vec[i] = 12'd20;
    vec[5] = 12'd8;
    thresh = 12'd10;
    begin_search();
    thresh = 12'd0;
    feed(6, 1'b0);
    expect_result("early", 12'd8, 8'h11);
    chk("early_flag", 32'(out_early), 32'd1);
    step();
    chk("early_in_ready_after", 32'(in_ready), 32'd0);
    release_result("early");
    chk("early_flag_clear", 32'(out_early), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
